id_branch_unit: RTL and testbench
=================================

# id_branch_unit

IF/ID pipeline register and branch resolver for the MIPS pipeline. It captures each fetched instruction and its address from the IF stage, and resolves BEQ, BNE and J in the ID stage. It drives the redirect pair (`br_taken`, `br_addr`) back to IF. On a redirect it replaces the wrong-path instruction(s) with a bubble, and it keeps saturating branch statistics.

## Interface
Parameters:
- `FLUSH_SLOTS`, default 1: number of IF/ID loads replaced by bubbles after a redirect. Legal range is 1..3.

Ports:
- `clk`  in  1  clock; reset `rst`, asynchronous, active-high.
- `rst`  in  1  asynchronous active-high reset.
- `freeze`  in  1  hazard stall. Holds the IF/ID register, the FSM and the counters. The same signal stalls IF.
- `if_pc`  in  32  address of the instruction currently in IF.
- `if_instruction`  in  32  instruction word currently in IF.
- `rs_val`  in  32  register-file read of `id_instruction[25:21]`.
- `rt_val`  in  32  register-file read of `id_instruction[20:16]`.
- `id_pc`  out  32  registered instruction address.
- `id_instruction`  out  32  registered instruction word; 0 (NOP) for a bubble.
- `id_valid`  out  1  high when the IF/ID register holds a real instruction.
- `br_taken`  out  1  redirect request to IF, combinational.
- `br_addr`  out  32  redirect target, combinational.
- `stat_branches`  out  32  count of resolved branch/jump instructions.
- `stat_taken`  out  32  count of redirects.

## Operation
- Decode from `id_instruction[31:26]`:
  - `6'b000100` BEQ
  - `6'b000101` BNE
  - `6'b000010` J
  - anything else is not a branch.
- Target address, with `pc4 = id_pc + 4`:
  - BEQ/BNE: `pc4 + (sign_extend(id_instruction[15:0]) << 2)`, modulo 2^32 (wraps, no error).
  - J: `{pc4[31:28], id_instruction[25:0], 2'b00}`.
- `br_taken = id_valid & ~freeze & (J | (BEQ & rs_val==rt_val) | (BNE & rs_val!=rt_val))`.
- `br_addr` is the target whenever the ID instruction is a branch. Otherwise it is 0.
- FSM states: RUN, SQUASH; squash counter `sq_cnt`, 2 bits.
- Transitions and IF/ID loads, on each edge with `freeze=0`:
  - RUN, `br_taken=0`: load `if_pc`/`if_instruction`, set `id_valid=1`.
  - RUN, `br_taken=1`: load a bubble (`id_pc=if_pc`, `id_instruction=0`, `id_valid=0`).
    - If `FLUSH_SLOTS>1`: go to SQUASH with `sq_cnt=FLUSH_SLOTS-1`.
    - Otherwise: stay in RUN.
  - SQUASH: load a bubble and decrement `sq_cnt`. When `sq_cnt` reaches 0, return to RUN.
- A branch cannot fire during SQUASH, because `id_valid=0` there.
- Edges with `freeze=1`: all state holds, including the IF/ID register, FSM, `sq_cnt` and counters.
- Statistics, updated on edges with `freeze=0`:
  - `stat_branches` increments when `id_valid` is high and the instruction decodes as BEQ/BNE/J.
  - `stat_taken` increments when `br_taken=1`.
  - Both saturate at `32'hFFFF_FFFF`.

## Timing
- Reset values:
  - `id_pc=0`, `id_instruction=0`, `id_valid=0`.
  - `br_taken=0`, `br_addr=0`.
  - `stat_branches=0`, `stat_taken=0`.
  - FSM in RUN, `sq_cnt=0`.
- Reset takes effect immediately, with no clock edge needed. It also aborts SQUASH.
- IF to ID latency: 1 cycle.
- Redirect is generated in the same cycle the branch sits in ID, so IF loads the target on that edge.
- Wrong-path bubbles: exactly `FLUSH_SLOTS` consecutive unfrozen edges starting at the redirect edge.
- A `freeze` during SQUASH stretches the squash window. The number of bubbles does not change.
- A `freeze` in the same cycle as a resolving branch suppresses `br_taken`. The branch resolves on the first unfrozen cycle, using the `rs_val`/`rt_val` of that cycle.

## Structure
- Shared package:
  - opcode constants `OP_BEQ`, `OP_BNE`, `OP_J`.
  - `NOP_WORD = 32'h0000_0000`.
  - FSM state enum `br_state_t` {RUN, SQUASH}.
- One sub-module: `branch_target_calc`. It is combinational: decode plus target computation from `id_pc` and `id_instruction`, outputting `is_branch`, `is_jump` and `target`.
- The FSM, IF/ID register and counters live in `id_branch_unit`.

## Test plan
- Reset mid-run: assert `rst` asynchronously while in SQUASH -> all outputs immediately 0, `id_valid=0`, FSM in RUN.
- Taken BEQ: `id_pc=0x100`, instruction `0x1022_0003`, `rs_val=rt_val=5` -> `br_taken=1`, `br_addr=0x110`, next `id_instruction=0`, `id_valid=0`, `stat_taken=1`.
- Not-taken BNE with negative offset: imm `0xFFFE`, `rs_val=rt_val` -> `br_taken=0`, `br_addr=0x0FC` (from `id_pc=0x100`), next IF word loaded with `id_valid=1`, `stat_branches` increments.
- Jump wrap: `id_pc=0xFFFF_FFFC`, J with `target[25:0]=0x40` -> `br_addr=0x0000_0100`, `br_taken=1`.
- `FLUSH_SLOTS=3` with freeze: taken J, then `freeze=1` for 2 cycles during SQUASH -> exactly 3 bubbles, first valid load on the 3rd unfrozen edge after redirect.
- Counter saturation: preload `stat_taken=0xFFFF_FFFF` via force, then a taken BEQ -> value stays `0xFFFF_FFFF`.

Source files
------------

// File: rtl/id_branch_unit_pkg.sv
// id_branch_unit_pkg
//   Shared definitions for the IF/ID register and branch resolver:
//   MIPS opcode constants, the bubble instruction word, the flush FSM
//   state type and a saturating counter increment helper.
package id_branch_unit_pkg;

    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_BNE   = 6'b000101;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN,
        SQUASH
    } br_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/id_branch_unit_target_calc.sv
// branch_target_calc
//   Combinational decode and target computation for the instruction in ID.
//   Ports:
//     pc          in  32  address of the ID instruction
//     instruction in  32  ID instruction word
//     is_beq      out  1  opcode is BEQ
//     is_bne      out  1  opcode is BNE
//     is_jump     out  1  opcode is J
//     is_branch   out  1  any of BEQ/BNE/J
//     target      out 32  redirect target; 0 when not a branch/jump
module branch_target_calc
    import id_branch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        is_beq,
    output logic        is_bne,
    output logic        is_jump,
    output logic        is_branch,
    output logic [31:0] target
);

    logic [31:0] pc4;
    logic [31:0] br_off;

    always_comb begin
        pc4       = pc + 32'd4;
        // Sign-extended word offset; the add below wraps modulo 2^32.
        br_off    = {{14{instruction[15]}}, instruction[15:0], 2'b00};
        is_beq    = (instruction[31:26] == OP_BEQ);
        is_bne    = (instruction[31:26] == OP_BNE);
        is_jump   = (instruction[31:26] == OP_J);
        is_branch = is_beq | is_bne | is_jump;
        target    = '0;
        if (is_jump) begin
            target = {pc4[31:28], instruction[25:0], 2'b00};
        end else if (is_beq | is_bne) begin
            target = pc4 + br_off;
        end
    end

endmodule

// File: rtl/id_branch_unit.sv
// id_branch_unit
//   IF/ID pipeline register with ID-stage resolution of BEQ/BNE/J. Drives the
//   combinational redirect pair back to IF, replaces FLUSH_SLOTS wrong-path
//   loads with bubbles and keeps saturating branch statistics.
//   Parameters:
//     FLUSH_SLOTS  bubbles inserted per redirect (1..3)
//   Ports:
//     clk, rst (async, active-high), freeze (hazard stall, holds all state)
//     if_pc, if_instruction     IF stage address / word
//     rs_val, rt_val            register reads for the ID instruction
//     id_pc, id_instruction, id_valid   registered IF/ID contents
//     br_taken, br_addr         redirect request / target to IF
//     stat_branches, stat_taken saturating statistics
module id_branch_unit #(
    parameter int unsigned FLUSH_SLOTS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken
);

    import id_branch_unit_pkg::*;

    localparam logic [1:0] SQ_INIT = 2'(FLUSH_SLOTS - 1);

    br_state_t   state_q, state_d;
    logic [1:0]  sq_cnt_q, sq_cnt_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_taken_q, stat_taken_d;

    logic        is_beq, is_bne, is_jump, is_branch;
    logic [31:0] target;
    logic        take;

    branch_target_calc u_target_calc (
        .pc          (id_pc_q),
        .instruction (id_instr_q),
        .is_beq      (is_beq),
        .is_bne      (is_bne),
        .is_jump     (is_jump),
        .is_branch   (is_branch),
        .target      (target)
    );

    always_comb begin
        take = id_valid_q & ~freeze &
               (is_jump | (is_beq & (rs_val == rt_val)) | (is_bne & (rs_val != rt_val)));
    end

    always_comb begin
        state_d         = state_q;
        sq_cnt_d        = sq_cnt_q;
        id_pc_d         = id_pc_q;
        id_instr_d      = id_instr_q;
        id_valid_d      = id_valid_q;
        stat_branches_d = stat_branches_q;
        stat_taken_d    = stat_taken_q;

        if (!freeze) begin
            // Bubble by default; only an untaken RUN cycle loads the IF word.
            id_pc_d    = if_pc;
            id_instr_d = NOP_WORD;
            id_valid_d = 1'b0;

            unique case (state_q)
                RUN: begin
                    if (take) begin
                        if (FLUSH_SLOTS > 1) begin
                            state_d  = SQUASH;
                            sq_cnt_d = SQ_INIT;
                        end
                    end else begin
                        id_instr_d = if_instruction;
                        id_valid_d = 1'b1;
                    end
                end
                SQUASH: begin
                    sq_cnt_d = sq_cnt_q - 2'd1;
                    if (sq_cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase

            if (id_valid_q & is_branch) begin
                stat_branches_d = sat_inc(stat_branches_q);
            end
            if (take) begin
                stat_taken_d = sat_inc(stat_taken_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            sq_cnt_q        <= '0;
            id_pc_q         <= '0;
            id_instr_q      <= NOP_WORD;
            id_valid_q      <= 1'b0;
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else begin
            state_q         <= state_d;
            sq_cnt_q        <= sq_cnt_d;
            id_pc_q         <= id_pc_d;
            id_instr_q      <= id_instr_d;
            id_valid_q      <= id_valid_d;
            stat_branches_q <= stat_branches_d;
            stat_taken_q    <= stat_taken_d;
        end
    end

    assign id_pc          = id_pc_q;
    assign id_instruction = id_instr_q;
    assign id_valid       = id_valid_q;
    assign br_taken       = take;
    assign br_addr        = target;
    assign stat_branches  = stat_branches_q;
    assign stat_taken     = stat_taken_q;

endmodule

// File: tb/tb_id_branch_unit.sv
// tb_id_branch_unit
//   Scoreboard bench: two instances (FLUSH_SLOTS = 1 and 3) share stimulus.
//   Each cycle the stimulus process pushes the reference model's expected
//   outputs per instance; a monitor pops and compares shortly afterwards.
module tb_id_branch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        val;
        logic        tk;
        logic [31:0] addr;
        logic [31:0] sb;
        logic [31:0] st;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_ins = '0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;

    logic [31:0] pc_o [2];
    logic [31:0] ins_o [2];
    logic        val_o [2];
    logic        tk_o [2];
    logic [31:0] addr_o [2];
    logic [31:0] sb_o [2];
    logic [31:0] st_o [2];

    int checks = 0;
    int failures = 0;

    obs_t q0[$];
    obs_t q1[$];
    event issued;

    // Reference model state, per instance
    int          fs [2] = '{1, 3};
    logic [31:0] m_pc [2];
    logic [31:0] m_ins [2];
    logic        m_val [2];
    int          m_left [2];
    logic [31:0] m_sb [2];
    logic [31:0] m_st [2];

    always #5 clk = ~clk;

    id_branch_unit #(.FLUSH_SLOTS(1)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze), .if_pc(if_pc), .if_instruction(if_ins),
        .rs_val(rs), .rt_val(rt), .id_pc(pc_o[0]), .id_instruction(ins_o[0]),
        .id_valid(val_o[0]), .br_taken(tk_o[0]), .br_addr(addr_o[0]),
        .stat_branches(sb_o[0]), .stat_taken(st_o[0])
    );

    id_branch_unit #(.FLUSH_SLOTS(3)) dut3 (
        .clk(clk), .rst(rst), .freeze(freeze), .if_pc(if_pc), .if_instruction(if_ins),
        .rs_val(rs), .rt_val(rt), .id_pc(pc_o[1]), .id_instruction(ins_o[1]),
        .id_valid(val_o[1]), .br_taken(tk_o[1]), .br_addr(addr_o[1]),
        .stat_branches(sb_o[1]), .stat_taken(st_o[1])
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_target(logic [31:0] pc, logic [31:0] ins);
        logic [31:0] n;
        int          off;
        n = pc + 32'd4;
        if (ins[31:26] == 6'd2) return (n & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
        off = $signed(ins[15:0]);
        return n + 32'(off * 4);
    endfunction

    function automatic logic [31:0] sat(logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = '0; m_ins[k] = '0; m_val[k] = 1'b0;
            m_left[k] = 0; m_sb[k] = '0; m_st[k] = '0;
        end
    endtask

    task automatic push_exp(int k, obs_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One clock cycle: drive inputs, record expectations, advance the model
    // across the upcoming rising edge.
    task automatic cycle(input logic frz, input logic [31:0] ipc, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        freeze = frz; if_pc = ipc; if_ins = ins; rs = a; rt = b;
        for (int k = 0; k < 2; k++) begin
            logic [5:0] op;
            logic       isbr, tk;
            obs_t       e;
            op   = m_ins[k][31:26];
            isbr = (op == 6'd4) || (op == 6'd5) || (op == 6'd2);
            tk   = m_val[k] && !frz &&
                   ((op == 6'd2) || (op == 6'd4 && a == b) || (op == 6'd5 && a != b));
            e.pc = m_pc[k]; e.ins = m_ins[k]; e.val = m_val[k]; e.tk = tk;
            e.addr = isbr ? ref_target(m_pc[k], m_ins[k]) : 32'd0;
            e.sb = m_sb[k]; e.st = m_st[k];
            push_exp(k, e);
            if (!frz) begin
                if (m_val[k] && isbr) m_sb[k] = sat(m_sb[k]);
                if (tk) begin
                    m_st[k] = sat(m_st[k]);
                    m_left[k] = fs[k];
                end
                m_pc[k] = ipc;
                if (m_left[k] > 0) begin
                    m_ins[k] = '0; m_val[k] = 1'b0; m_left[k]--;
                end else begin
                    m_ins[k] = ins; m_val[k] = 1'b1;
                end
            end
        end
        ->issued;
    endtask

    task automatic do_reset();
        obs_t z;
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        z = '0;
        push_exp(0, z);
        push_exp(1, z);
        ->issued;
        #1;
        chk("async_reset_valid3", {31'd0, val_o[1]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares every issued expectation against the DUT outputs.
    initial begin
        forever begin
            @(issued);
            #1;
            for (int k = 0; k < 2; k++) begin
                obs_t e;
                bit   have;
                have = 1'b0;
                if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    checks++; failures++;
                    $display("FAIL scoreboard_empty dut%0d: got none expected entry", k);
                end else begin
                    chk($sformatf("dut%0d.id_pc", k), pc_o[k], e.pc);
                    chk($sformatf("dut%0d.id_instruction", k), ins_o[k], e.ins);
                    chk($sformatf("dut%0d.id_valid", k), {31'd0, val_o[k]}, {31'd0, e.val});
                    chk($sformatf("dut%0d.br_taken", k), {31'd0, tk_o[k]}, {31'd0, e.tk});
                    chk($sformatf("dut%0d.br_addr", k), addr_o[k], e.addr);
                    chk($sformatf("dut%0d.stat_branches", k), sb_o[k], e.sb);
                    chk($sformatf("dut%0d.stat_taken", k), st_o[k], e.st);
                end
            end
        end
    end

    localparam logic [31:0] FILL = 32'h2408_0007;

    initial begin
        model_reset();
        #2;
        push_exp(0, obs_t'(0));
        push_exp(1, obs_t'(0));
        ->issued;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Taken BEQ
        cycle(0, 32'h100, 32'h1022_0003, 0, 0);
        cycle(0, 32'h104, FILL, 5, 5);
        #1;
        chk("beq_taken", {31'd0, tk_o[0]}, 32'd1);
        chk("beq_addr", addr_o[0], 32'h110);
        cycle(0, 32'h110, 32'h2409_0001, 0, 0);
        #1;
        chk("beq_bubble_ins", ins_o[0], 32'd0);
        chk("beq_bubble_valid", {31'd0, val_o[0]}, 32'd0);
        chk("beq_stat_taken", st_o[0], 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 32'h114 + 32'(4 * i), FILL, 0, 1);

        // Not-taken BNE with negative offset
        cycle(0, 32'h100, 32'h1422_FFFE, 0, 0);
        cycle(0, 32'h104, FILL, 7, 7);
        #1;
        chk("bne_not_taken", {31'd0, tk_o[0]}, 32'd0);
        chk("bne_addr", addr_o[0], 32'h0FC);
        cycle(0, 32'h108, 32'h0, 0, 0);
        #1;
        chk("bne_next_valid", {31'd0, val_o[0]}, 32'd1);
        chk("bne_next_ins", ins_o[0], FILL);
        chk("bne_stat_branches", sb_o[0], 32'd2);

        // Jump wrap, then freeze inside the FLUSH_SLOTS=3 squash window
        cycle(0, 32'hFFFF_FFFC, 32'h0800_0040, 0, 0);
        cycle(0, 32'h200, FILL, 0, 0);
        #1;
        chk("j_taken1", {31'd0, tk_o[0]}, 32'd1);
        chk("j_taken3", {31'd0, tk_o[1]}, 32'd1);
        chk("j_addr", addr_o[1], 32'h0000_0100);
        cycle(1, 32'h100, 32'h2409_0011, 0, 0);
        cycle(1, 32'h100, 32'h2409_0011, 0, 0);
        cycle(0, 32'h100, 32'h2409_0011, 0, 0);
        cycle(0, 32'h104, 32'h2409_0022, 0, 0);
        cycle(0, 32'h108, 32'h2409_0033, 0, 0);
        #1;
        chk("squash_last_bubble", {31'd0, val_o[1]}, 32'd0);
        cycle(0, 32'h10C, FILL, 0, 0);
        #1;
        chk("squash_first_valid", {31'd0, val_o[1]}, 32'd1);
        chk("squash_first_ins", ins_o[1], 32'h2409_0033);

        // Reset while dut3 is squashing
        cycle(0, 32'h300, 32'h0800_0100, 0, 0);
        cycle(0, 32'h304, FILL, 0, 0);
        do_reset();
        cycle(0, 32'h400, FILL, 0, 0);
        cycle(0, 32'h404, 32'h0, 0, 0);
        #1;
        chk("run_after_reset", {31'd0, val_o[1]}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 32'h408 + 32'(4 * i), FILL, 0, 1);

        // Saturation; the frozen cycle also shows freeze suppressing br_taken
        cycle(0, 32'h500, 32'h1022_0003, 0, 0);
        cycle(1, 32'h504, FILL, 5, 5);
        #1;
        chk("freeze_suppresses", {31'd0, tk_o[0]}, 32'd0);
        #1;
        force dut1.stat_taken_q = 32'hFFFF_FFFF;
        force dut3.stat_taken_q = 32'hFFFF_FFFF;
        force dut1.stat_branches_q = 32'hFFFF_FFFF;
        force dut3.stat_branches_q = 32'hFFFF_FFFF;
        #1;
        release dut1.stat_taken_q;
        release dut3.stat_taken_q;
        release dut1.stat_branches_q;
        release dut3.stat_branches_q;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 32'hFFFF_FFFF;
            m_sb[k] = 32'hFFFF_FFFF;
        end
        cycle(0, 32'h504, FILL, 9, 9);
        cycle(0, 32'h508, FILL, 0, 0);
        #1;
        chk("stat_taken_saturated", st_o[0], 32'hFFFF_FFFF);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] w, pc, a, b;
            w = $urandom;
            case ($urandom_range(0, 4))
                0: w[31:26] = 6'd4;
                1: w[31:26] = 6'd5;
                2: w[31:26] = 6'd2;
                default: ;
            endcase
            pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                              : ($urandom & 32'hFFFF_FFFC);
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            cycle(($urandom_range(0, 4) == 0), pc, w, a, b);
        end

        #20;
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
